// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional wait-state timeout enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       SCL,
    input  logic       SDA,
    output logic       scl_low,
    output logic       sda_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error
);

    // state   | meaning
    // IDLE    | lines released, ready for a byte
    // INHIBIT | SCL held low; SDA pulled low in the final cycle (request-to-send)
    // BITS    | shift data, parity, stop on device SCL falling edges
    // ACK     | sample device ACK on the next falling edge
    // RELEASE | wait for device to release both lines
    typedef enum logic [2:0] {IDLE, INHIBIT, BITS, ACK, RELEASE} state_t;

    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_SDA  = CW'((INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_idx;
    logic [9:0]      frame;
    logic            scl_s1, scl_s2, scl_prev;
    logic            sda_s1, sda_s2;
    logic            scl_fall;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
        end else begin
            scl_s1   <= SCL;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= SDA;
            sda_s2   <= sda_s1;
        end
    end

    assign scl_fall = scl_prev & ~scl_s2;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            scl_low  <= 1'b0;
            sda_low  <= 1'b0;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            frame    <= '0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    scl_low  <= 1'b0;
                    sda_low  <= 1'b0;
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        // frame = {stop, odd parity, data}; start bit comes from the RTS pull-down
                        frame    <= {1'b1, ~^tx_data, tx_data};
                        cnt      <= '0;
                        scl_low  <= 1'b1;
                        sda_low  <= (INHIBIT_CYCLES == 1);
                        tx_ready <= 1'b0;
                        state    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == INH_SDA) sda_low <= 1'b1;
                    if (cnt == INH_LAST) begin
                        scl_low <= 1'b0;
                        bit_idx <= '0;
                        cnt     <= '0;
                        state   <= BITS;
                    end
                end
                BITS: begin
                    if (scl_fall) begin
                        sda_low <= ~frame[bit_idx];
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'd9) state <= ACK;
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        if (!sda_s2) begin
                            state <= RELEASE;
                        end else begin
                            tx_error <= 1'b1;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                RELEASE: begin
                    if (scl_s2 && sda_s2) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
            // Timeout overrides any same-cycle completion so done/error never coincide.
            if (state == BITS || state == ACK || state == RELEASE) begin
                if (scl_fall) begin
                    cnt <= '0;
                end else if (cnt == TMO_LAST) begin
                    scl_low  <= 1'b0;
                    sda_low  <= 1'b0;
                    tx_error <= 1'b1;
                    tx_done  <= 1'b0;
                    tx_ready <= 1'b1;
                    cnt      <= '0;
                    state    <= IDLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
`endif
        end
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The module SHALL have parameter INHIBIT_CYCLES, default 5000, meaning clk cycles SCL is held low before the start bit (100 us at 50 MHz).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 750000, meaning the maximum clk cycles to wait for any device SCL falling edge (15 ms at 50 MHz).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 SCL  input  1  PS/2 clock line as read from the pad, asynchronous.
REQ-006 SDA  input  1  PS/2 data line as read from the pad, asynchronous.
REQ-007 scl_low  output  1  open-drain control: 1 = drive SCL low, 0 = release.
REQ-008 sda_low  output  1  open-drain control: 1 = drive SDA low, 0 = release.
REQ-009 tx_data  input  8  byte to send to the device.
REQ-010 tx_valid  input  1  request; the byte is accepted when tx_valid and tx_ready are both 1 on a clk edge.
REQ-011 tx_ready  output  1  1 only in IDLE.
REQ-012 tx_done  output  1  one-cycle pulse: frame sent and acknowledged.
REQ-013 tx_error  output  1  one-cycle pulse: missing ACK or timeout.

Function
REQ-014 The module SHALL synchronise SCL and SDA through two flip-flops each, and SHALL detect SCL falling edges on the synchronised value (previous 1, current 0).
REQ-015 The frame SHALL be: start bit 0, tx_data bits 0..7 (LSB first), odd parity, then stop bit 1.
  - The parity bit makes the count of ones over data plus parity odd.
REQ-016 The state machine SHALL have states IDLE, INHIBIT, BITS, ACK and RELEASE.
  - All states other than IDLE and INHIBIT are "wait states".
REQ-017 On acceptance, the module SHALL:
  - latch tx_data and the computed parity;
  - clear the cycle counter;
  - enter INHIBIT with scl_low=1 from the next cycle.
REQ-018 INHIBIT SHALL work as follows:
  - scl_low=1 for exactly INHIBIT_CYCLES cycles;
  - sda_low rises to 1 in the last of those cycles;
  - then scl_low drops to 0, bit index is set to 0, and the state becomes BITS.
REQ-019 In BITS, on each SCL falling edge the module SHALL set sda_low = NOT(frame bit index) and then increment index.
  - Index order: data0..data7 = 0..7, parity = 8, stop = 9.
  - The start bit is held until the first falling edge.
  - After index 9 is driven (sda_low=0), the state becomes ACK.
REQ-020 In ACK, on the next SCL falling edge the module SHALL sample the synchronised SDA.
  - 0: go to RELEASE.
  - 1: pulse tx_error and go to IDLE.
REQ-021 In RELEASE, the module SHALL wait until synchronised SCL=1 and SDA=1, then pulse tx_done and go to IDLE.
REQ-022 tx_valid SHALL be ignored in every state except IDLE; tx_data changes after acceptance SHALL not affect the frame in flight.
REQ-023 In IDLE, both scl_low and sda_low SHALL be 0.
REQ-024 tx_done and tx_error SHALL never be 1 in the same cycle.
REQ-025 Cycle counter width SHALL be sized by $clog2 of the larger parameter and SHALL NOT wrap within one wait state.

Reset
REQ-026 While RST=0, the module SHALL force: state IDLE, scl_low=0, sda_low=0, tx_ready=0, tx_done=0, tx_error=0, counter 0, bit index 0, synchronisers 1.
REQ-027 tx_ready SHALL become 1 on the first clk edge after RST is released.
REQ-028 Reset asserted mid-frame SHALL release both lines immediately (asynchronously), with no tx_done or tx_error pulse.

Configuration
REQ-029 Macro PS2_HOST_TX_TIMEOUT_EN SHALL control the timeout.
  - Defined: the counter restarts on entry to each wait state and on every SCL falling edge. On reaching TIMEOUT_CYCLES in a wait state, the module releases both lines, pulses tx_error, and goes to IDLE.
  - Undefined: no timeout logic; wait states wait indefinitely.

Verification
REQ-030 Basic send: send 0xF4, device model clocks 11 edges with ACK=0 -> SDA bits after start read 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses once; tx_ready returns to 1.
REQ-031 Inhibit timing: send 0xED -> scl_low high for exactly INHIBIT_CYCLES cycles; sda_low rises in the last of them; parity bit 1.
REQ-032 Missing ACK: send 0x00, device leaves SDA=1 at the ACK edge -> tx_error pulses once, no tx_done, lines released.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=100): device stops clocking after 4 edges -> tx_error at cycle 100 after the last edge, both lines released, IDLE.
REQ-034 Busy and reset: tx_valid=1 with 0x55 while a frame is in flight -> ignored. Then RST=0 mid-frame -> scl_low=sda_low=0 at once, and after release tx_ready=1 with no pulses.
